// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract engine.
// A single 1-bit full adder is stepped over WIDTH clock cycles, LSB first.
// The host uses a start/busy/done handshake. The result, carry and overflow
// flags are registered and held until the next accepted operation completes.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] r_sh;
    logic             carry;
    logic [CW-1:0]    count;

    logic             fa_a;
    logic             fa_b;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic [WIDTH-1:0] r_next;

    // The one and only full adder: it works on the current LSBs and the running carry
    assign fa_a    = a_sh[0];
    assign fa_b    = b_sh[0];
    assign fa_sum  = fa_a ^ fa_b ^ carry;
    assign fa_cout = (fa_a & fa_b) | (carry & (fa_a ^ fa_b));

    // Partial result after this bit is shifted in; on the last bit this is the full word
    assign r_next   = {fa_sum, r_sh};
    assign last_bit = (count == CW'(WIDTH - 1));

    // Handshake outputs are decoded directly from the state register
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Sequencer: load operands on start, shift one bit per cycle, publish the result on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            carry     <= 1'b0;
            count     <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b ^ {WIDTH{sub}};
                        carry <= sub;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    r_sh  <= r_next[WIDTH-1:1];
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_cout;
                    count <= count + 1'b1;
                    if (last_bit) begin
                        // On the MSB step, carry holds the carry into the MSB, so
                        // signed overflow is that carry XOR the carry out of the MSB.
                        result    <= r_next;
                        carry_out <= fa_cout;
                        overflow  <= fa_cout ^ carry;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and randomized checks of serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;

    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [7:0] res8;
    logic       cy8, ov8;

    logic       start2, sub2;
    logic [1:0] a2, b2;
    logic       busy2, done2;
    logic [1:0] res2;
    logic       cy2, ov2;

    int checks = 0;
    int errors = 0;

    logic [7:0] heldR;
    logic       heldC;
    logic       heldV;

    logic [7:0] sa [40];
    logic [7:0] sb [40];
    logic       ss [40];

    // Free-running clock, period 10
    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8),
        .op_a(a8), .op_b(b8), .busy(busy8), .done(done8),
        .result(res8), .carry_out(cy8), .overflow(ov8)
    );

    serial_add_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2),
        .op_a(a2), .op_b(b2), .busy(busy2), .done(done2),
        .result(res2), .carry_out(cy2), .overflow(ov2)
    );

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model using the sign-rule definition of overflow; returns {v, c, r}
    function automatic logic [9:0] model(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        int mask, aa, bb, full, r, c, sga, sgb, sgr;
        logic v;
        mask = (1 << w) - 1;
        aa   = int'(a) & mask;
        bb   = s ? (~int'(b)) & mask : int'(b) & mask;
        full = aa + bb + (s ? 1 : 0);
        r    = full & mask;
        c    = (full >> w) & 1;
        sga  = (aa >> (w - 1)) & 1;
        sgb  = (bb >> (w - 1)) & 1;
        sgr  = (r >> (w - 1)) & 1;
        v    = (sga == sgb) && (sgr != sga);
        return {v, c[0], r[7:0]};
    endfunction

    // Present a start request on the selected DUT at the falling edge
    task automatic applyStimulus(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if (w == 8) begin
            start8 = 1'b1; sub8 = s; a8 = a; b8 = b;
        end else begin
            start2 = 1'b1; sub2 = s; a2 = a[1:0]; b2 = b[1:0];
        end
    endtask

    // Issue one operation and wait (bounded) for done; ends with the DUT back in IDLE
    task automatic runOp(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] r, output logic c, output logic v,
                         output int lat, output int busyCnt, output logic overlap);
        logic bsy, dn;
        applyStimulus(w, s, a, b);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start2 = 1'b0;
        lat = -1;
        busyCnt = 0;
        overlap = 1'b0;
        bsy = (w == 8) ? busy8 : busy2;
        if (bsy) busyCnt++;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bsy = (w == 8) ? busy8 : busy2;
            dn  = (w == 8) ? done8 : done2;
            if (bsy && dn) overlap = 1'b1;
            if (bsy) busyCnt++;
            if (dn) begin
                lat = k;
                break;
            end
        end
        r = (w == 8) ? res8 : {6'b0, res2};
        c = (w == 8) ? cy8 : cy2;
        v = (w == 8) ? ov8 : ov2;
        @(posedge clk);
        #1;
    endtask

    // Run one operation and compare its outcome and timing against the expectations given
    task automatic doOp(input string tag, input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ec, input logic ev);
        logic [7:0] r;
        logic c, v, overlap;
        int lat, busyCnt;
        runOp(w, s, a, b, r, c, v, lat, busyCnt, overlap);
        checkOutput({tag, "_result"}, 32'(r), 32'(er));
        checkOutput({tag, "_carry"}, 32'(c), 32'(ec));
        checkOutput({tag, "_ovf"}, 32'(v), 32'(ev));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(w));
        checkOutput({tag, "_busycycles"}, 32'(busyCnt), 32'(w));
        checkOutput({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        if (w == 8) begin
            heldR = er; heldC = ec; heldV = ev;
        end
    endtask

    // Directed sequence followed by randomized operations at both widths
    initial begin
        logic [9:0] m;
        logic [7:0] ra, rb;
        logic       rs;
        int         phase;
        logic       sawDone;

        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
        heldR = '0; heldC = 1'b0; heldV = 1'b0;

        #12;
        checkOutput("reset_busy", 32'(busy8), 32'd0);
        checkOutput("reset_done", 32'(done8), 32'd0);
        checkOutput("reset_result", 32'(res8), 32'd0);
        checkOutput("reset_carry", 32'(cy8), 32'd0);
        checkOutput("reset_ovf", 32'(ov8), 32'd0);
        checkOutput("reset_busy_w2", 32'(busy2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        doOp("add_5a_3c", 8, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
        doOp("add_ff_01", 8, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        doOp("add_00_00", 8, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        doOp("sub_10_20", 8, 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        doOp("sub_80_01", 8, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

        // start held high with fresh operands every cycle; accepts land every 10 cycles
        for (int k = 0; k < 40; k++) begin
            sa[k] = 8'(k * 37 + 5);
            sb[k] = 8'(k * 11 + 3);
            ss[k] = 1'((k >> 1) & 1);
            @(negedge clk);
            start8 = 1'b1; a8 = sa[k]; b8 = sb[k]; sub8 = ss[k];
            @(posedge clk);
            #1;
            phase = k % 10;
            checkOutput("stream_busy", 32'(busy8), 32'(phase < 8));
            checkOutput("stream_done", 32'(done8), 32'(phase == 8));
            if (phase == 8) begin
                m = model(8, ss[k - 8], sa[k - 8], sb[k - 8]);
                heldR = m[7:0]; heldC = m[8]; heldV = m[9];
            end
            checkOutput("stream_result", 32'(res8), 32'(heldR));
            checkOutput("stream_carry", 32'(cy8), 32'(heldC));
            checkOutput("stream_ovf", 32'(ov8), 32'(heldV));
        end
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a run aborts it without a done pulse
        applyStimulus(8, 1'b0, 8'h77, 8'h11);
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrun_busy_before_rst", 32'(busy8), 32'd1);
        checkOutput("midrun_result_held", 32'(res8), 32'(heldR));
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrun_rst_busy", 32'(busy8), 32'd0);
        checkOutput("midrun_rst_done", 32'(done8), 32'd0);
        checkOutput("midrun_rst_result", 32'(res8), 32'd0);
        checkOutput("midrun_rst_carry", 32'(cy8), 32'd0);
        checkOutput("midrun_rst_ovf", 32'(ov8), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        heldR = '0; heldC = 1'b0; heldV = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done8) sawDone = 1'b1;
        end
        checkOutput("midrun_no_done", 32'(sawDone), 32'd0);
        checkOutput("postrst_result_zero", 32'(res8), 32'd0);
        doOp("add_12_34", 8, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

        // Randomized operations against the reference model
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            m  = model(8, rs, ra, rb);
            doOp("rand_w8", 8, rs, ra, rb, m[7:0], m[8], m[9]);
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 3));
            rb = 8'($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            m  = model(2, rs, ra, rb);
            doOp("rand_w2", 2, rs, ra, rb, m[7:0], m[8], m[9]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract engine. Sequences exactly one 1-bit full-adder instance (a, b, cin -> sum, cout) over WIDTH cycles, LSB first.
- Replaces a WIDTH-bit ripple array where area matters more than latency.
- Start/busy/done handshake to a host controller. Result, carry and signed-overflow flags are registered and held until the next accepted operation completes.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
sub  input  1  0 = a+b, 1 = a-b; sampled with start
op_a  input  WIDTH  operand a; sampled with start
op_b  input  WIDTH  operand b; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/flags valid from this cycle
result  output  WIDTH  registered sum/difference
carry_out  output  1  final adder cout (in sub mode 1 = no borrow)
overflow  output  1  two's-complement overflow

Behaviour:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset (async assert, any state): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; all internal shift registers, carry and count cleared.
- Reset mid-operation aborts the operation: no done pulse, outputs zeroed. The first start after rst deasserts behaves normally.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge: load A<=op_a, B<=op_b XOR {WIDTH{sub}}, carry<=sub, count<=0; go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - full-adder inputs are a=A[0], b=B[0], cin=carry;
  - R <= {sum, R[WIDTH-1:1]}; A and B shift right by 1; carry<=cout; count<=count+1;
  - cmsb <= carry when count==WIDTH-1 (carry into the MSB).
- RUN, edge with count==WIDTH-1: go to DONE and update the outputs at the same edge:
  - result <= {sum, R[WIDTH-1:1]};
  - carry_out <= cout;
  - overflow <= cout XOR carry (carry into MSB).
- DONE: done=1 for exactly one cycle; go to IDLE on the next edge.
- busy = (state==RUN), decoded combinationally from the state register. done = (state==DONE).
- Latency: start sampled at edge E0 -> bits 0..WIDTH-1 processed at edges E1..E_WIDTH -> done high during the cycle after E_WIDTH.
- Earliest next start is sampled at E_(WIDTH+2), giving a back-to-back period of WIDTH+2 cycles.
- start is ignored in RUN and DONE. No queuing, no error flag.
- op_a, op_b and sub are don't-care except at the accepting edge; changes mid-run have no effect.
- result, carry_out and overflow change only at the RUN->DONE edge or on reset. They are stable in IDLE, RUN and DONE otherwise, including during a subsequent run.
- Arithmetic is modulo 2^WIDTH. Subtraction is a + ~b + 1; carry_out=0 means a borrow occurred (unsigned a<b).
- count width is clog2(WIDTH); no wrap is reachable because the FSM leaves RUN at WIDTH-1.
- Exactly one full-adder instance. No WIDTH-bit adder may be inferred.

Test Plan:
- WIDTH=8, add 0x5A+0x3C -> result=0x96, carry_out=0, overflow=1. done rises exactly in the cycle after the 8th edge following the start edge; busy high for 8 cycles.
- Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0. Add 0x00+0x00 -> result=0x00, carry_out=0, overflow=0.
- Sub 0x10-0x20 -> result=0xF0, carry_out=0, overflow=0. Sub 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1.
- start held high continuously with new operands every cycle:
  - operations are accepted every 10 cycles;
  - operands changed during RUN/DONE do not alter results;
  - done is a single-cycle pulse each time;
  - the previous result is held until the next done.
- Assert rst asynchronously (mid-cycle) after 3 RUN edges -> busy=0, all outputs 0 immediately, no done pulse. The next op 0x12+0x34 -> 0x46.
- Randomized 1000 ops at WIDTH=8 and WIDTH=2 vs. reference model (sum, carry, signed overflow). Also check that busy and done are never both high.
